// File: rtl/dcache_line_adapter.sv
// Bridges the data cache's 256-bit line port to 4-beat, 64-bit memory bursts:
// reads gather beats into a fill line, writes split a victim line into beats.
module dcache_line_adapter #(
  parameter int BEAT_WIDTH  = 64,
  parameter int BEATS       = 4,
  parameter int OFFSET_BITS = 5,
  localparam int LINE_WIDTH = BEAT_WIDTH * BEATS,
  localparam int CNT_W      = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i,
  output logic [1:0]            dbg_state_o
);

  // Handshake: cache side holds read_i/write_i high until the one-cycle resp_o
  // pulse; memory side advances one beat on every cycle resp_i is high while
  // read_o/write_o is asserted, and resp_i stalls the burst when low.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_BURST = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [LINE_WIDTH-1:0]   r_wbuf;
  logic [LINE_WIDTH-1:0]   r_line;
  logic [31:0]             r_addr;
  logic                    r_read;
  logic                    r_write;
  logic                    r_resp;
  logic [31:0]             w_addr_aligned;

  assign w_addr_aligned = address_i & ADDR_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wbuf  <= '0;
      r_line  <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Writeback must precede the fill when both are requested.
          if (write_i) begin
            r_wbuf  <= line_i;
            r_addr  <= w_addr_aligned;
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_state <= S_WR_BURST;
          end else if (read_i) begin
            r_addr  <= w_addr_aligned;
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= S_RD_BURST;
          end
        end
        S_RD_BURST: begin
          if (resp_i) begin
            r_line[BEAT_WIDTH*r_cnt +: BEAT_WIDTH] <= burst_i;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WR_BURST: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign burst_o     = (r_state == S_WR_BURST) ? r_wbuf[BEAT_WIDTH*r_cnt +: BEAT_WIDTH]
                                               : '0;
  assign line_o      = r_line;
  assign address_o   = r_addr;
  assign read_o      = r_read;
  assign write_o     = r_write;
  assign resp_o      = r_resp;
  assign dbg_state_o = r_state;

endmodule
